div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider, signed or unsigned, with zero-divisor and flush handling.
// Define DIV_EARLY_EXIT_EN to skip the leading zero bits of the dividend magnitude.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             flush,
  output logic             ready,
  output logic             validOut,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             divZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dzo_q, dzo_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [CW-1:0]    iters;
  logic [WIDTH-1:0] dvd_init;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign sign_a = sign & SrcA[WIDTH-1];
  assign sign_b = sign & SrcB[WIDTH-1];
  assign mag_a  = sign_a ? ('0 - SrcA) : SrcA;
  assign mag_b  = sign_b ? ('0 - SrcB) : SrcB;

`ifdef DIV_EARLY_EXIT_EN
  // Position of the leading one plus one; a zero dividend still runs one step.
  function automatic logic [CW-1:0] lead_count(input logic [WIDTH-1:0] v);
    lead_count = CW'(1);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) lead_count = CW'(i + 1);
    end
  endfunction

  // Pre-shifting the dividend left makes the skipped steps the leading-zero ones,
  // which would only have shifted zeros into remainder and quotient.
  assign iters    = lead_count(mag_a);
  assign dvd_init = mag_a << (CW'(WIDTH) - iters);
`else
  assign iters    = CW'(WIDTH);
  assign dvd_init = mag_a;
`endif

  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign rem_ge = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = rem_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], rem_ge};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zdiv_d  = zdiv_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dzo_d   = dzo_q;

    unique case (state_q)
      IDLE: begin
        if (validIn && !flush) begin
          state_d = CALC;
          zdiv_d  = (SrcB == '0);
          // A zero divisor keeps the raw dividend for the remainder output.
          dvd_d   = (SrcB == '0) ? SrcA : dvd_init;
          dvs_d   = mag_b;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = iters;
          qneg_d  = sign_a ^ sign_b;
          rneg_d  = sign_a;
        end
      end
      CALC: begin
        if (zdiv_q) begin
          state_d = DONE;
          lo_d    = '1;
          hi_d    = dvd_q;
          dzo_d   = 1'b1;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            lo_d    = qneg_q ? ('0 - quo_nx) : quo_nx;
            hi_d    = rneg_q ? ('0 - rem_nx) : rem_nx;
            dzo_d   = 1'b0;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dzo_d   = dzo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zdiv_q  <= zdiv_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dzo_q   <= dzo_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign validOut = (state_q == DONE);
  assign Lo       = lo_q;
  assign Hi       = hi_q;
  assign divZero  = dzo_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed bench for div_unit against a plain-arithmetic reference model.
module tb_div_unit;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         validIn;
  logic         sign;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         flush;
  logic         ready;
  logic         validOut;
  logic [W-1:0] Lo;
  logic [W-1:0] Hi;
  logic         divZero;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] last_lo, last_hi;
  logic         last_dz;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .validIn  (validIn),
    .sign     (sign),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .flush    (flush),
    .ready    (ready),
    .validOut (validOut),
    .Lo       (Lo),
    .Hi       (Hi),
    .divZero  (divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic truncates toward zero and cannot overflow here.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
    longint sa, sb, q, r;
    if (b == 0) begin
      lo = '1; hi = a; dz = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
      dz = 1'b0;
    end
  endtask

  function automatic int exp_latency(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    int k;
    if (b == 0) return 1;
    m = (s && a[W-1]) ? -a : a;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
`ifdef DIV_EARLY_EXIT_EN
    return k;
`else
    return (k > 0) ? W : W;
`endif
  endfunction

  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    validIn = 1'b1; sign = s; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    validIn = 1'b0;
    sign = 1'($urandom); SrcA = $urandom; SrcB = $urandom;
    check("busy_after_accept", {63'd0, ready}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] elo, ehi;
    logic edz;
    int lat;
    model(s, a, b, elo, ehi, edz);
    start_op(s, a, b);
    lat = 999;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (validOut) begin lat = n; break; end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_latency(s, a, b)));
    check({tag, "_lo"}, {32'd0, Lo}, {32'd0, elo});
    check({tag, "_hi"}, {32'd0, Hi}, {32'd0, ehi});
    check({tag, "_dz"}, {63'd0, divZero}, {63'd0, edz});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {62'd0, validOut, ready}, 64'd1);
    last_lo = elo; last_hi = ehi; last_dz = edz;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic s;
    int pulses;

    validIn = 0; sign = 0; SrcA = '0; SrcB = '0; flush = 0;
    reset = 1'b1;
    #12;
    check("reset_state", {Lo, Hi}, 64'd0);
    check("reset_ctl", {61'd0, divZero, validOut, ready}, 64'd1);
    @(negedge clk); reset = 1'b0;

    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("sneg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("s7_neg2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("s_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u_minneg", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("zdiv", 1'b0, 32'd55, 32'd0);
    run_op("after_zdiv", 1'b0, 32'd1000, 32'd10);
    run_op("zero_dvd", 1'b1, 32'd0, 32'd5);
    run_op("s_zdiv", 1'b1, 32'hFFFF_FF00, 32'd0);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = b >> $urandom_range(0, 31);
        3: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op("rand", s, a, b);
    end

    // Flush mid-computation: no pulse, outputs keep the previous result.
    run_op("pre_flush", 1'b0, 32'd77, 32'd5);
    start_op(1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush_ready", {62'd0, validOut, ready}, 64'd1);
    @(negedge clk); flush = 1'b0;
    pulses = 0;
    for (int n = 0; n < W + 5; n++) begin
      @(posedge clk); #1;
      if (validOut) pulses++;
    end
    check("flush_nopulse", 64'(pulses), 64'd0);
    check("flush_hold", {Lo, Hi}, {last_lo, last_hi});
    check("flush_hold_dz", {63'd0, divZero}, {63'd0, last_dz});

    // validIn with flush in IDLE must not accept.
    @(negedge clk); validIn = 1'b1; flush = 1'b1; SrcA = 32'd9; SrcB = 32'd2;
    @(posedge clk); #1;
    check("flush_idle_ready", {63'd0, ready}, 64'd1);
    @(negedge clk); validIn = 1'b0; flush = 1'b0;

    // validIn during CALC is neither honoured nor queued.
    begin
      logic [W-1:0] elo, ehi;
      logic edz;
      int lat;
      model(1'b0, 32'd100, 32'd7, elo, ehi, edz);
      start_op(1'b0, 32'd100, 32'd7);
      @(negedge clk); validIn = 1'b1; SrcA = 32'd50; SrcB = 32'd3;
      @(negedge clk); validIn = 1'b0;
      lat = 999;
      for (int n = 2; n <= 100; n++) begin
        @(posedge clk); #1;
        if (validOut) begin lat = n; break; end
      end
      check("ign_lat", 64'(lat), 64'(exp_latency(1'b0, 32'd100, 32'd7)));
      check("ign_res", {Lo, Hi}, {elo, ehi});
      pulses = 0;
      for (int n = 0; n < W + 5; n++) begin
        @(posedge clk); #1;
        if (validOut) pulses++;
      end
      check("ign_noqueue", 64'(pulses), 64'd0);
    end

    // Asynchronous reset mid-computation.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_out", {Lo, Hi}, 64'd0);
    check("arst_ctl", {61'd0, divZero, validOut, ready}, 64'd1);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < W + 5; n++) begin
      @(posedge clk); #1;
      if (validOut) pulses++;
    end
    check("arst_nopulse", 64'(pulses), 64'd0);
    run_op("s9_3", 1'b1, 32'd9, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
